tv_stream_unpacker: RTL and testbench

//  Unpacks a 32-bit test-vector transaction stream into a stream of DATA_WIDTH_IN task words.

---
 rtl/tv_stream_unpacker_if.sv | 45 ++++
 rtl/tv_stream_unpacker.sv | 229 ++++++++++++++++++++++
 tb/tb_tv_stream_unpacker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tv_stream_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : tv_stream_unpacker_if
//  Description : Stream bundle for tv_stream_unpacker. Carries the wide input
//                beat stream (s_*) and the narrow output word stream (m_*).
//                The unpacker uses the slave modport. The feeding/draining
//                environment uses the master modport.
//  Signals     : s_data [BUS_W]   input beat, lane 0 = bits [WORD_W-1:0]
//                s_valid/s_last   input valid / final beat of frame
//                s_ready          input ready (from unpacker)
//                m_data [WORD_W]  output word (from unpacker)
//                m_valid/m_last   output valid / final word of frame
//                m_ready          output ready (to unpacker)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tv_stream_unpacker_if #(
    parameter int BUS_W  = 32,
    parameter int WORD_W = 8
);
    logic [BUS_W-1:0]  s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    // Environment side: sources beats, sinks words.
    modport master (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  m_data, m_valid, m_last,
        output m_ready
    );

    // Unpacker side: sinks beats, sources words.
    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready,
        output m_data, m_valid, m_last,
        input  m_ready
    );
endinterface
`default_nettype wire

// File: rtl/tv_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tv_stream_unpacker
//  Description : Unpacks BUS_W-bit test-vector beats into WORD_W-bit task
//                words. Frame length is loaded at runtime via cfg_load.
//                Generates m_last, drops padding lanes of the final beat,
//                and checks beat framing (early/late s_last). Frames with a
//                late s_last are flushed up to and including the s_last beat.
//  Ports       : clk, rst (async, active-high)
//                cfg_num_words/cfg_load  frame length, start pulse (IDLE only)
//                busy       high outside IDLE
//                done       one-cycle pulse at frame end
//                frame_err  sticky framing error, cleared by accepted cfg_load
//                err_cnt    (TV_UNPACK_ERR_CNT_EN only) saturating count of
//                           frames with a framing error, cleared by rst only
//                strm       tv_stream_unpacker_if.slave (s_* in, m_* out)
//  Option      : define TV_UNPACK_ERR_CNT_EN to add err_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module tv_stream_unpacker #(
    parameter int BUS_W     = 32,
    parameter int WORD_W    = 8,
    parameter int MAX_WORDS = 4096,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_num_words,
    input  logic             cfg_load,
`ifdef TV_UNPACK_ERR_CNT_EN
    output logic [15:0]      err_cnt,
`endif
    output logic             busy,
    output logic             done,
    output logic             frame_err,
    tv_stream_unpacker_if.slave strm
);

    localparam int                c_lanes     = BUS_W / WORD_W;
    localparam int                c_lane_w    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam logic [CNT_W-1:0]  c_max_words = CNT_W'(MAX_WORDS);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [BUS_W-1:0]    r_buf;
    logic                r_buf_valid;
    logic                r_buf_last;
    logic [c_lane_w-1:0] r_lane;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_done;
    logic                r_frame_err;

    logic [CNT_W-1:0]    w_num_sat;
    logic [WORD_W-1:0]   w_m_data;
    logic                w_m_valid;
    logic                w_m_last;
    logic                w_m_fire;
    logic                w_last_lane;
    logic                w_final_word;
    logic                w_beat_end;
    logic                w_frame_end;
    logic                w_s_ready;
    logic                w_s_fire;
    logic                w_load;
    logic                w_done_next;
    logic                w_err_set;

    assign w_num_sat = (cfg_num_words > c_max_words) ? c_max_words : cfg_num_words;

    // Lane select of the buffered beat.
    always_comb begin
        w_m_data = '0;
        for (int i = 0; i < c_lanes; i++) begin
            if (r_lane == c_lane_w'(i)) begin
                w_m_data = r_buf[i*WORD_W +: WORD_W];
            end
        end
    end

    assign w_m_valid    = (r_state == ST_RUN) && r_buf_valid;
    assign w_last_lane  = (r_lane == c_last_lane);
    assign w_final_word = (r_remaining == CNT_W'(1));
    // The final needed word closes the frame; a beat flagged s_last before the
    // frame is complete closes it on its top lane instead.
    assign w_m_last     = w_m_valid && (w_final_word || (r_buf_last && w_last_lane));
    // A beat is exhausted on its top lane or when it supplies the final word
    // (remaining lanes are padding and are never presented).
    assign w_beat_end   = w_last_lane || w_final_word;
    assign w_m_fire     = w_m_valid && strm.m_ready;
    assign w_frame_end  = w_m_fire && w_m_last;
    assign w_s_fire     = strm.s_valid && w_s_ready;

    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_load) begin
                    w_load = 1'b1;
                    if (w_num_sat == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Refill when empty or when the current beat is drained this
                // cycle. Once the s_last beat has delivered the frame's last
                // word, the next beat belongs to a frame not yet loaded.
                w_s_ready = !r_buf_valid ||
                            (w_m_fire && w_beat_end && !(w_m_last && r_buf_last));
                if (w_frame_end) begin
                    if (r_buf_last) begin
                        // Normal end, or early s_last when words are still owed.
                        w_err_set    = !w_final_word;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        // Late s_last: the beat accepted alongside the final
                        // word is already a discard beat.
                        w_err_set = 1'b1;
                        if (strm.s_valid && strm.s_last) begin
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                w_s_ready = 1'b1;
                if (strm.s_valid && strm.s_last) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_last  <= 1'b0;
            r_lane      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_load) begin
                r_frame_err <= 1'b0;
            end else if (w_err_set) begin
                r_frame_err <= 1'b1;
            end
            if (w_load) begin
                r_remaining <= w_num_sat;
                r_buf_valid <= 1'b0;
                r_buf_last  <= 1'b0;
                r_lane      <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_m_fire) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (w_beat_end) begin
                        r_buf_valid <= 1'b0;
                        r_lane      <= '0;
                    end else begin
                        r_lane <= r_lane + c_lane_w'(1);
                    end
                end
                // A new beat overrides the drain update above.
                if (w_s_fire && !w_frame_end) begin
                    r_buf       <= strm.s_data;
                    r_buf_valid <= 1'b1;
                    r_buf_last  <= strm.s_last;
                    r_lane      <= '0;
                end
            end
        end
    end

`ifdef TV_UNPACK_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_set && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign frame_err    = r_frame_err;
    assign strm.s_ready = w_s_ready;
    assign strm.m_valid = w_m_valid;
    assign strm.m_last  = w_m_last;
    assign strm.m_data  = w_m_data;

endmodule
`default_nettype wire

// File: tb/tb_tv_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tv_stream_unpacker
//  Description : Self-checking bench for tv_stream_unpacker. Two instances
//                (8-bit and 16-bit words) share the beat source. A frame
//                model derives the expected word list, m_last position,
//                frame_err and done count from frame length and s_last beat.
//                Define TV_UNPACK_ERR_CNT_EN to also check err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tv_stream_unpacker;

    localparam int BUS_W     = 32;
    localparam int MAX_WORDS = 4096;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cfg_num_words;
    logic             cfg_load8, cfg_load16;
    logic [BUS_W-1:0] s_data;
    logic             s_valid, s_last, m_ready;
    logic             busy8, done8, ferr8, busy16, done16, ferr16;
`ifdef TV_UNPACK_ERR_CNT_EN
    logic [15:0]      err_cnt8, err_cnt16;
`endif

    int total = 0;
    int bad   = 0;
    int exp_err8, exp_err16;

    always #5 clk = ~clk;

    tv_stream_unpacker_if #(.BUS_W(BUS_W), .WORD_W(8))  if8 ();
    tv_stream_unpacker_if #(.BUS_W(BUS_W), .WORD_W(16)) if16 ();

    assign if8.s_data   = s_data;
    assign if8.s_valid  = s_valid;
    assign if8.s_last   = s_last;
    assign if8.m_ready  = m_ready;
    assign if16.s_data  = s_data;
    assign if16.s_valid = s_valid;
    assign if16.s_last  = s_last;
    assign if16.m_ready = m_ready;

    tv_stream_unpacker #(.BUS_W(BUS_W), .WORD_W(8), .MAX_WORDS(MAX_WORDS)) u_dut8 (
        .clk           (clk),
        .rst           (rst),
        .cfg_num_words (cfg_num_words),
        .cfg_load      (cfg_load8),
`ifdef TV_UNPACK_ERR_CNT_EN
        .err_cnt       (err_cnt8),
`endif
        .busy          (busy8),
        .done          (done8),
        .frame_err     (ferr8),
        .strm          (if8)
    );

    tv_stream_unpacker #(.BUS_W(BUS_W), .WORD_W(16), .MAX_WORDS(MAX_WORDS)) u_dut16 (
        .clk           (clk),
        .rst           (rst),
        .cfg_num_words (cfg_num_words),
        .cfg_load      (cfg_load16),
`ifdef TV_UNPACK_ERR_CNT_EN
        .err_cnt       (err_cnt16),
`endif
        .busy          (busy16),
        .done          (done16),
        .frame_err     (ferr16),
        .strm          (if16)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on the selected instance. lastbeat is the 1-based beat that
    // carries s_last; abort_after>0 returns once that many words are seen.
    task automatic run_frame(input bit w16, input int n, input int nbeats, input int lastbeat,
                             input int rdy_pct, input int abort_after, input string tag);
        int          lanes, wbits, nsat, k, n_exp, bp, dones, cyc, budget, nlast;
        bit          exp_err, stop, prev_stall, prev_ml;
        logic [31:0] mask, prev_md, md;
        logic        mv, ml, sr, dn;
        logic [31:0] beats[$];
        logic [31:0] exp_w[$];
        logic [31:0] got_w[$];
        bit          got_l[$];
        int          got_c[$];

        lanes = w16 ? 2 : 4;
        wbits = w16 ? 16 : 8;
        mask  = w16 ? 32'h0000_FFFF : 32'h0000_00FF;
        nsat  = (n > MAX_WORDS) ? MAX_WORDS : n;
        k     = (nsat + lanes - 1) / lanes;
        if (lastbeat < k) begin
            n_exp   = lastbeat * lanes;
            exp_err = 1'b1;
        end else begin
            n_exp   = nsat;
            exp_err = (lastbeat != k);
        end
        for (int i = 0; i < nbeats; i++) beats.push_back($urandom());
        for (int w = 0; w < n_exp; w++)
            exp_w.push_back((beats[w / lanes] >> ((w % lanes) * wbits)) & mask);

        @(negedge clk);
        cfg_num_words = CNT_W'(n);
        if (w16) cfg_load16 = 1'b1; else cfg_load8 = 1'b1;
        @(negedge clk);
        cfg_load8  = 1'b0;
        cfg_load16 = 1'b0;
        #1;
        check($sformatf("%s_busy", tag), w16 ? busy16 : busy8, nsat > 0);

        bp = 0; dones = 0; cyc = 0; stop = 0; prev_stall = 0; prev_md = '0; prev_ml = 0;
        budget = 4 * (n_exp + nbeats) + 50;
        while (!stop && cyc < budget) begin
            if (bp < nbeats) begin
                s_valid = 1'b1;
                s_data  = beats[bp];
                s_last  = (bp + 1 == lastbeat);
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
                s_last  = 1'b0;
            end
            m_ready = ($urandom_range(99) < rdy_pct);
            // A stray load mid-frame must be ignored.
            cfg_num_words = CNT_W'(1);
            cfg_load8  = !w16 && (cyc == 3) && (n_exp > 12);
            cfg_load16 = w16 && (cyc == 3) && (n_exp > 12);
            #1;
            sr = w16 ? if16.s_ready : if8.s_ready;
            mv = w16 ? if16.m_valid : if8.m_valid;
            ml = w16 ? if16.m_last  : if8.m_last;
            md = w16 ? {16'h0, if16.m_data} : {24'h0, if8.m_data};
            dn = w16 ? done16 : done8;
            if (prev_stall)
                check($sformatf("%s_hold_c%0d", tag, cyc), {mv, ml, md}, {1'b1, prev_ml, prev_md});
            if (mv && !m_ready)
                check($sformatf("%s_sready_stall_c%0d", tag, cyc), sr, 1'b0);
            if (mv && m_ready) begin
                got_w.push_back(md);
                got_l.push_back(ml);
                got_c.push_back(cyc);
            end
            if (s_valid && sr) bp++;
            if (dn) begin
                dones++;
                stop = 1'b1;
            end
            if (abort_after > 0 && got_w.size() == abort_after) stop = 1'b1;
            prev_stall = mv && !m_ready;
            prev_md    = md;
            prev_ml    = ml;
            if (!stop) begin
                @(negedge clk);
                cyc++;
            end
        end
        cfg_load8  = 1'b0;
        cfg_load16 = 1'b0;

        if (abort_after > 0) begin
            check($sformatf("%s_reached", tag), got_w.size(), abort_after);
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            m_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                #1;
                if (w16 ? done16 : done8) dones++;
            end
            check($sformatf("%s_done_cnt", tag), dones, 1);
            check($sformatf("%s_words", tag), got_w.size(), n_exp);
            for (int i = 0; i < got_w.size() && i < n_exp; i++)
                check($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
            nlast = 0;
            foreach (got_l[i]) if (got_l[i]) nlast++;
            check($sformatf("%s_nlast", tag), nlast, (n_exp > 0) ? 1 : 0);
            if (n_exp > 0 && got_l.size() > 0)
                check($sformatf("%s_last_pos", tag), got_l[got_l.size() - 1], 1'b1);
            check($sformatf("%s_frame_err", tag), w16 ? ferr16 : ferr8, exp_err);
            check($sformatf("%s_idle", tag),
                  {w16 ? busy16 : busy8, w16 ? if16.s_ready : if8.s_ready, w16 ? if16.m_valid : if8.m_valid},
                  3'b000);
            if (rdy_pct == 100 && got_c.size() > 1)
                check($sformatf("%s_rate", tag), got_c[got_c.size() - 1] - got_c[0] + 1, n_exp);
            if (exp_err) begin
                if (w16) exp_err16++; else exp_err8++;
            end
`ifdef TV_UNPACK_ERR_CNT_EN
            check($sformatf("%s_err_cnt", tag), w16 ? err_cnt16 : err_cnt8, w16 ? exp_err16 : exp_err8);
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_num_words = '0; cfg_load8 = 1'b0; cfg_load16 = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        exp_err8 = 0; exp_err16 = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst8_ctl", {busy8, done8, ferr8, if8.s_ready, if8.m_valid, if8.m_last}, 6'b0);
        check("rst8_data", if8.m_data, 8'h00);
        check("rst16_ctl", {busy16, done16, ferr16, if16.s_ready, if16.m_valid, if16.m_last}, 6'b0);
        rst = 1'b0;

        run_frame(1'b0, 1000, 250, 250, 100, 0, "long");
        run_frame(1'b1, 5, 3, 3, 100, 0, "w16_n5");
        run_frame(1'b0, 16, 4, 4, 50, 0, "bp16");
        run_frame(1'b0, 8, 1, 1, 100, 0, "early");
        run_frame(1'b0, 4, 3, 3, 100, 0, "late");
        run_frame(1'b0, 4, 2, 2, 100, 0, "late_direct");
        run_frame(1'b0, 0, 0, 0, 100, 0, "zero");
        run_frame(1'b0, 7, 2, 2, 60, 0, "n7");
        run_frame(1'b0, 5000, 1024, 1024, 100, 0, "sat");

        for (int r = 0; r < 10; r++) begin
            int n, k, mode, lb;
            n    = $urandom_range(40, 1);
            k    = (n + 3) / 4;
            mode = $urandom_range(2, 0);
            if (mode == 1 && k > 1) lb = $urandom_range(k - 1, 1);
            else if (mode == 2)     lb = k + $urandom_range(3, 1);
            else                    lb = k;
            run_frame(1'b0, n, lb, lb, $urandom_range(100, 30), 0, $sformatf("rnd%0d", r));
        end

        // Mid-frame reset: outputs drop asynchronously, no done follows.
        run_frame(1'b0, 1000, 250, 250, 100, 10, "abort");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ctl", {busy8, done8, ferr8, if8.s_ready, if8.m_valid, if8.m_last}, 6'b0);
        check("abort_data", if8.m_data, 8'h00);
`ifdef TV_UNPACK_ERR_CNT_EN
        check("abort_err_cnt", err_cnt8, 16'h0);
`endif
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("abort_nodone", done8, 1'b0);
        end
        rst = 1'b0;
        exp_err8  = 0;
        exp_err16 = 0;
        @(negedge clk);
        #1;
        check("post_rst_nodone", done8, 1'b0);
        run_frame(1'b0, 4, 1, 1, 100, 0, "post_rst");
        run_frame(1'b1, 6, 3, 3, 70, 0, "w16_n6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
